block_read_reducer: RTL and testbench

//   Downstream consumer of the multiplier's block-read stream. On request it pulses EN_blockRead,

---
 rtl/block_read_reducer.sv | 115 +++++++++++
 tb/tb_block_read_reducer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_read_reducer.sv
// Block-read consumer: requests one block from the multiplier, reduces the beats to
// sum/max/min/count and holds the result until the consumer takes it.
module block_read_reducer #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 64,
  parameter int ACC_WIDTH = WIDTH + 6,
  parameter int TIMEOUT   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       EN_reduce,
  output logic                       RDY_reduce,
  output logic                       EN_blockRead,
  input  logic                       VALID_memVal,
  input  logic [WIDTH-1:0]           memVal_data,
  output logic                       VALID_result,
  input  logic                       EN_resultTaken,
  output logic [ACC_WIDTH-1:0]       result_sum,
  output logic [WIDTH-1:0]           result_max,
  output logic [WIDTH-1:0]           result_min,
  output logic [$clog2(DEPTH):0]     result_count,
  output logic                       ERR_timeout
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, COLLECT, DONE} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [WIDTH-1:0]     min_q, min_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      max_q   <= '0;
      min_q   <= '1;
      count_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      min_q   <= min_d;
      count_q <= count_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    max_d   = max_q;
    min_d   = min_q;
    count_d = count_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (EN_reduce) begin
          state_d = REQ;
          sum_d   = '0;
          max_d   = '0;
          min_d   = '1;
          count_d = '0;
          wd_d    = '0;
          err_d   = 1'b0;
        end
      end
      REQ: state_d = COLLECT;
      COLLECT: begin
        if (VALID_memVal) begin
          sum_d   = sum_q + ACC_WIDTH'(memVal_data);
          if (memVal_data > max_q) max_d = memVal_data;
          if (memVal_data < min_q) min_d = memVal_data;
          count_d = count_q + CNT_W'(1);
          wd_d    = '0;
          if (count_q == CNT_W'(DEPTH - 1)) state_d = DONE;
        end else begin
          // Watchdog expiry keeps whatever partial reduction was gathered.
          wd_d = wd_q + WD_W'(1);
          if (wd_q == WD_W'(TIMEOUT - 1)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      DONE: begin
        if (EN_resultTaken) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign RDY_reduce   = (state_q == IDLE);
  assign EN_blockRead = (state_q == REQ);
  assign VALID_result = (state_q == DONE);
  assign result_sum   = sum_q;
  assign result_max   = max_q;
  assign result_min   = min_q;
  assign result_count = count_q;
  assign ERR_timeout  = err_q;

endmodule

// File: tb/tb_block_read_reducer.sv
// Randomised self-checking bench for block_read_reducer; expected results come from a
// queue of driven beats reduced with plain arithmetic.
module tb_block_read_reducer;

  localparam int W       = 32;
  localparam int DEPTH   = 64;
  localparam int ACC_W   = W + 6;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              EN_reduce = 1'b0;
  logic              RDY_reduce;
  logic              EN_blockRead;
  logic              VALID_memVal = 1'b0;
  logic [W-1:0]      memVal_data = '0;
  logic              VALID_result;
  logic              EN_resultTaken = 1'b0;
  logic [ACC_W-1:0]  result_sum;
  logic [W-1:0]      result_max;
  logic [W-1:0]      result_min;
  logic [CNT_W-1:0]  result_count;
  logic              ERR_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;

  logic [W-1:0]     sent_q[$];
  logic [ACC_W-1:0] exp_sum;
  logic [W-1:0]     exp_max, exp_min;
  logic [CNT_W-1:0] exp_count;
  logic             exp_err;

  block_read_reducer #(.WIDTH(W), .DEPTH(DEPTH), .ACC_WIDTH(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .EN_reduce(EN_reduce), .RDY_reduce(RDY_reduce), .EN_blockRead(EN_blockRead),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
    .VALID_result(VALID_result), .EN_resultTaken(EN_resultTaken),
    .result_sum(result_sum), .result_max(result_max), .result_min(result_min),
    .result_count(result_count), .ERR_timeout(ERR_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (EN_blockRead === 1'b1) pulse_cnt++;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, limit 2000000 ns");
    $fatal(1, "[TB] hung");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference reduction: first DEPTH driven beats count, fewer than DEPTH means a timeout.
  task automatic model_expect();
    int n;
    n = (sent_q.size() > DEPTH) ? DEPTH : sent_q.size();
    exp_count = CNT_W'(n);
    exp_err   = (sent_q.size() < DEPTH);
    exp_sum   = '0;
    exp_max   = '0;
    exp_min   = '1;
    for (int i = 0; i < n; i++) begin
      exp_sum = exp_sum + ACC_W'(sent_q[i]);
      if (sent_q[i] > exp_max) exp_max = sent_q[i];
      if (sent_q[i] < exp_min) exp_min = sent_q[i];
    end
  endtask

  task automatic do_request();
    int k = 0;
    while (RDY_reduce !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (RDY_reduce !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL rdy_wait: RDY_reduce=%0b after %0d cycles, want 1", RDY_reduce, k);
    end
    sent_q.delete();
    EN_reduce = 1'b1;
    tick();
    EN_reduce = 1'b0;
    tick();
  endtask

  task automatic send_beat(input logic [W-1:0] d, input int gap);
    repeat (gap) begin
      VALID_memVal = 1'b0;
      memVal_data  = $urandom;
      tick();
    end
    VALID_memVal = 1'b1;
    memVal_data  = d;
    sent_q.push_back(d);
    tick();
    VALID_memVal = 1'b0;
    memVal_data  = $urandom;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (VALID_result !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (VALID_result !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL %s_wait: VALID_result=%0b after %0d cycles, want 1", name, VALID_result, k);
    end
  endtask

  task automatic take_result();
    EN_resultTaken = 1'b1;
    tick();
    EN_resultTaken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({RDY_reduce, EN_blockRead, VALID_result, ERR_timeout, result_sum, result_max, result_min, result_count}
        !== {1'b1, 1'b0, 1'b0, 1'b0, {ACC_W{1'b0}}, {W{1'b0}}, {W{1'b1}}, {CNT_W{1'b0}}}) begin
      n_bad++;
      $display("[TB] FAIL reset: got rdy=%0b en=%0b v=%0b err=%0b sum=%0d max=%0d min=%0h cnt=%0d, want 1 0 0 0 0 0 ffffffff 0",
               RDY_reduce, EN_blockRead, VALID_result, ERR_timeout, result_sum, result_max, result_min, result_count);
    end
  endtask

  task automatic test_full_burst();
    do_request();
    for (int i = 0; i < DEPTH; i++) begin
      send_beat(W'(i), 0);
      if (i == DEPTH - 2) begin
        n_cmp++;
        if (VALID_result !== 1'b0) begin
          n_bad++;
          $display("[TB] FAIL full_early_valid: VALID_result=%0b before last beat, want 0", VALID_result);
        end
      end
    end
    exp_sum = 2016; exp_max = 63; exp_min = 0; exp_count = 64; exp_err = 0;
    n_cmp++;
    if ({VALID_result, ERR_timeout, result_count, result_sum, result_max, result_min}
        !== {1'b1, exp_err, exp_count, exp_sum, exp_max, exp_min}) begin
      n_bad++;
      $display("[TB] FAIL full_burst: got v=%0b err=%0b cnt=%0d sum=%0d max=%0d min=%0d, want 1 %0b %0d %0d %0d %0d",
               VALID_result, ERR_timeout, result_count, result_sum, result_max, result_min,
               exp_err, exp_count, exp_sum, exp_max, exp_min);
    end
    take_result();
    n_cmp++;
    if ({RDY_reduce, VALID_result, ERR_timeout} !== 3'b100) begin
      n_bad++;
      $display("[TB] FAIL full_taken: got rdy/v/err=%b, want 100", {RDY_reduce, VALID_result, ERR_timeout});
    end
  endtask

  task automatic test_gaps();
    do_request();
    for (int i = 0; i < DEPTH; i++) send_beat(W'(i * i), $urandom_range(0, 3));
    wait_valid(4, "gaps");
    exp_sum = 85344; exp_max = 3969; exp_min = 0; exp_count = 64; exp_err = 0;
    n_cmp++;
    if ({ERR_timeout, result_count, result_sum, result_max, result_min}
        !== {exp_err, exp_count, exp_sum, exp_max, exp_min}) begin
      n_bad++;
      $display("[TB] FAIL gaps: got err=%0b cnt=%0d sum=%0d max=%0d min=%0d, want %0b %0d %0d %0d %0d",
               ERR_timeout, result_count, result_sum, result_max, result_min,
               exp_err, exp_count, exp_sum, exp_max, exp_min);
    end
    take_result();
  endtask

  task automatic test_timeout();
    do_request();
    for (int i = 0; i < 10; i++) send_beat(W'(5), 0);
    repeat (TIMEOUT - 1) tick();
    n_cmp++;
    if (VALID_result !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL timeout_early: VALID_result=%0b after %0d idle cycles, want 0", VALID_result, TIMEOUT - 1);
    end
    tick();
    exp_sum = 50; exp_max = 5; exp_min = 5; exp_count = 10; exp_err = 1;
    n_cmp++;
    if ({VALID_result, ERR_timeout, result_count, result_sum, result_max, result_min}
        !== {1'b1, exp_err, exp_count, exp_sum, exp_max, exp_min}) begin
      n_bad++;
      $display("[TB] FAIL timeout: got v=%0b err=%0b cnt=%0d sum=%0d max=%0d min=%0d, want 1 %0b %0d %0d %0d %0d",
               VALID_result, ERR_timeout, result_count, result_sum, result_max, result_min,
               exp_err, exp_count, exp_sum, exp_max, exp_min);
    end
    take_result();
    n_cmp++;
    if (ERR_timeout !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL timeout_clear: ERR_timeout=%0b after take, want 0", ERR_timeout);
    end
  endtask

  task automatic test_hold();
    do_request();
    for (int i = 0; i < DEPTH; i++) send_beat(W'(i), 0);
    exp_sum = 2016; exp_max = 63; exp_min = 0; exp_count = 64; exp_err = 0;
    for (int c = 0; c < 20; c++) begin
      EN_reduce = 1'($urandom_range(0, 1));
      tick();
      n_cmp++;
      if ({VALID_result, RDY_reduce, EN_blockRead, ERR_timeout, result_count, result_sum, result_max, result_min}
          !== {3'b100, exp_err, exp_count, exp_sum, exp_max, exp_min}) begin
        n_bad++;
        $display("[TB] FAIL hold_c%0d: got v=%0b rdy=%0b en=%0b err=%0b cnt=%0d sum=%0d max=%0d min=%0d, want 1 0 0 %0b %0d %0d %0d %0d",
                 c, VALID_result, RDY_reduce, EN_blockRead, ERR_timeout, result_count, result_sum, result_max, result_min,
                 exp_err, exp_count, exp_sum, exp_max, exp_min);
      end
    end
    EN_reduce = 1'b1;
    EN_resultTaken = 1'b1;
    tick();
    EN_reduce = 1'b0;
    EN_resultTaken = 1'b0;
    n_cmp++;
    if ({RDY_reduce, VALID_result, EN_blockRead} !== 3'b100) begin
      n_bad++;
      $display("[TB] FAIL hold_release: got rdy/v/en=%b, want 100", {RDY_reduce, VALID_result, EN_blockRead});
    end
    tick();
    n_cmp++;
    if ({RDY_reduce, EN_blockRead} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL hold_ignored_req: got rdy/en=%b, want 10", {RDY_reduce, EN_blockRead});
    end
  endtask

  task automatic test_reset_mid();
    do_request();
    for (int i = 0; i < 30; i++) send_beat($urandom, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({RDY_reduce, EN_blockRead, VALID_result, ERR_timeout, result_sum, result_max, result_min, result_count}
        !== {1'b1, 1'b0, 1'b0, 1'b0, {ACC_W{1'b0}}, {W{1'b0}}, {W{1'b1}}, {CNT_W{1'b0}}}) begin
      n_bad++;
      $display("[TB] FAIL reset_mid: got rdy=%0b en=%0b v=%0b err=%0b sum=%0d max=%0d min=%0h cnt=%0d, want 1 0 0 0 0 0 ffffffff 0",
               RDY_reduce, EN_blockRead, VALID_result, ERR_timeout, result_sum, result_max, result_min, result_count);
    end
    do_request();
    for (int i = 0; i < DEPTH; i++) send_beat($urandom, 0);
    model_expect();
    n_cmp++;
    if ({VALID_result, ERR_timeout, result_count, result_sum, result_max, result_min}
        !== {1'b1, exp_err, exp_count, exp_sum, exp_max, exp_min}) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_rerun: got v=%0b err=%0b cnt=%0d sum=%0d max=%0h min=%0h, want 1 %0b %0d %0d %0h %0h",
               VALID_result, ERR_timeout, result_count, result_sum, result_max, result_min,
               exp_err, exp_count, exp_sum, exp_max, exp_min);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulse_cnt;
    for (int r = 0; r < 2; r++) begin
      do_request();
      for (int i = 0; i < DEPTH; i++) send_beat(W'(i), 0);
      exp_sum = 2016; exp_max = 63; exp_min = 0; exp_count = 64; exp_err = 0;
      n_cmp++;
      if ({VALID_result, ERR_timeout, result_count, result_sum, result_max, result_min}
          !== {1'b1, exp_err, exp_count, exp_sum, exp_max, exp_min}) begin
        n_bad++;
        $display("[TB] FAIL b2b_r%0d: got v=%0b err=%0b cnt=%0d sum=%0d max=%0d min=%0d, want 1 %0b %0d %0d %0d %0d",
                 r, VALID_result, ERR_timeout, result_count, result_sum, result_max, result_min,
                 exp_err, exp_count, exp_sum, exp_max, exp_min);
      end
      take_result();
    end
    n_cmp++;
    if (pulse_cnt - p0 != 2) begin
      n_bad++;
      $display("[TB] FAIL b2b_pulses: EN_blockRead high for %0d cycles, want 2", pulse_cnt - p0);
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 8; b++) begin
      int mode, n, gap;
      mode = $urandom_range(0, 2);
      n = (mode == 0) ? DEPTH + $urandom_range(0, 3) : (mode == 1) ? $urandom_range(1, DEPTH - 1) : 0;
      do_request();
      for (int i = 0; i < n; i++) begin
        gap = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
        send_beat($urandom, (i < DEPTH) ? gap : 0);
      end
      wait_valid(TIMEOUT + 4, "random");
      model_expect();
      n_cmp++;
      if ({ERR_timeout, result_count, result_sum, result_max, result_min}
          !== {exp_err, exp_count, exp_sum, exp_max, exp_min}) begin
        n_bad++;
        $display("[TB] FAIL random_b%0d: got err=%0b cnt=%0d sum=%0d max=%0h min=%0h, want %0b %0d %0d %0h %0h",
                 b, ERR_timeout, result_count, result_sum, result_max, result_min,
                 exp_err, exp_count, exp_sum, exp_max, exp_min);
      end
      take_result();
    end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_gaps();
    test_timeout();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
